// File: rtl/siggen_pkg.sv
// Shared types and constants for the serial test-frame generator.
package siggen_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPreamble,
        StSync,
        StPayload
    } state_e;

    // PRBS15 (x^15 + x^14 + 1)
    localparam logic [14:0] Prbs15Taps = 15'h6000;
    localparam logic [14:0] Prbs15Seed = 15'h5555;

    // Counter width covering the longest section; never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/siggen_lfsr.sv
// Fibonacci LFSR with advance enable and seed load; an all-zero seed is replaced by 1.
module siggen_lfsr
    import siggen_pkg::*;
#(
    parameter int unsigned       Width = 15,
    parameter logic [Width-1:0]  Taps  = Width'(Prbs15Taps),
    parameter logic [Width-1:0]  Seed  = Width'(Prbs15Seed)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    output logic [Width-1:0] value,
    output logic [Width-1:0] value_next
);

    localparam logic [Width-1:0] SafeSeed = (Seed == '0) ? Width'(1) : Seed;

    logic [Width-1:0] lfsr_q;

    // Load wins over advance so a reseeded wrap starts the new frame from the seed.
    always_comb begin
        value_next = lfsr_q;
        if (load) begin
            value_next = SafeSeed;
        end else if (en) begin
            value_next = {lfsr_q[Width-2:0], ^(lfsr_q & Taps)};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= SafeSeed;
        end else begin
            lfsr_q <= value_next;
        end
    end

    assign value = lfsr_q;

endmodule

// File: rtl/frame_sig_gen.sv
// Serial frame generator: zero preamble, sync word, PRBS payload on a valid/ready stream.
// Define SIGGEN_ERR_INJECT_EN to add the err_inject payload-bit inversion input.
module frame_sig_gen
    import siggen_pkg::*;
#(
    parameter int unsigned            PREAMBLE_LEN = 160,
    parameter int unsigned            SYNC_LEN     = 8,
    parameter logic [31:0]            SYNC_WORD    = 32'hFF,
    parameter int unsigned            PAYLOAD_LEN  = 2048,
    parameter int unsigned            CAPTURE_LEN  = 8,
    parameter int unsigned            LFSR_WIDTH   = 15,
    parameter logic [LFSR_WIDTH-1:0]  LFSR_TAPS    = LFSR_WIDTH'(Prbs15Taps),
    parameter logic [LFSR_WIDTH-1:0]  LFSR_SEED    = LFSR_WIDTH'(Prbs15Seed)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   continuous,
    input  logic                   reseed,
`ifdef SIGGEN_ERR_INJECT_EN
    input  logic                   err_inject,
`endif
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic                   data_out,
    output logic                   busy,
    output logic                   frame_start,
    output logic                   frame_done,
    output logic [CAPTURE_LEN-1:0] first_sequence,
    output logic                   first_seq_valid
);

    localparam int unsigned CntW = cnt_width(PREAMBLE_LEN, SYNC_LEN, PAYLOAD_LEN);

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   valid_q, valid_d;
    logic                   data_q, data_d;
    logic                   busy_q;
    logic                   fs_q, fs_d;
    logic                   fd_q, fd_d;
    logic [CAPTURE_LEN-1:0] seq_q, seq_d;
    logic                   seqv_q, seqv_d;

    int unsigned            cnt_int;
    logic                   accept, tx_bit, frame_begin;
    logic                   last_pre, last_sync, last_pay;
    logic                   lfsr_en, lfsr_load;
    logic [LFSR_WIDTH-1:0]  lfsr_value, lfsr_next;

    function automatic logic sync_bit(input int unsigned idx);
        logic [31:0] sh;
        sh = SYNC_WORD >> (SYNC_LEN - 1 - idx);
        return sh[0];
    endfunction

    assign cnt_int   = 32'(cnt_q);
    assign accept    = valid_q & out_ready;
    assign last_pre  = (cnt_int == PREAMBLE_LEN - 1);
    assign last_sync = (cnt_int == SYNC_LEN - 1);
    assign last_pay  = (cnt_int == PAYLOAD_LEN - 1);

    // Kept outside the FSM process so the LFSR next value has no false loop back into it.
    assign lfsr_en     = accept & (state_q == StPayload);
    assign frame_begin = ((state_q == StIdle) & start) | (lfsr_en & last_pay & continuous);
    assign lfsr_load   = frame_begin & reseed;

`ifdef SIGGEN_ERR_INJECT_EN
    assign tx_bit = data_q ^ (err_inject & valid_q & (state_q == StPayload));
`else
    assign tx_bit = data_q;
`endif

    siggen_lfsr #(
        .Width (LFSR_WIDTH),
        .Taps  (LFSR_TAPS),
        .Seed  (LFSR_SEED)
    ) u_lfsr (
        .clk        (clk),
        .reset      (reset),
        .en         (lfsr_en),
        .load       (lfsr_load),
        .value      (lfsr_value),
        .value_next (lfsr_next)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        data_d  = data_q;
        fs_d    = 1'b0;
        fd_d    = 1'b0;
        seq_d   = seq_q;
        seqv_d  = seqv_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StPreamble;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    data_d  = 1'b0;
                end
            end
            StPreamble: begin
                if (accept) begin
                    if (last_pre) begin
                        state_d = StSync;
                        cnt_d   = '0;
                        data_d  = sync_bit(0);
                    end else begin
                        cnt_d  = cnt_q + CntW'(1);
                        data_d = 1'b0;
                    end
                end
            end
            StSync: begin
                if (accept) begin
                    if (last_sync) begin
                        state_d = StPayload;
                        cnt_d   = '0;
                        data_d  = lfsr_value[LFSR_WIDTH-1];
                    end else begin
                        cnt_d  = cnt_q + CntW'(1);
                        data_d = sync_bit(cnt_int + 1);
                    end
                end
            end
            StPayload: begin
                if (accept) begin
                    if (cnt_int < CAPTURE_LEN) begin
                        seq_d = seq_q | (CAPTURE_LEN'(tx_bit) << (CAPTURE_LEN - 1 - cnt_int));
                        if (cnt_int == CAPTURE_LEN - 1) seqv_d = 1'b1;
                    end
                    if (last_pay) begin
                        fd_d   = 1'b1;
                        cnt_d  = '0;
                        data_d = 1'b0;
                        if (continuous) begin
                            state_d = StPreamble;
                        end else begin
                            state_d = StIdle;
                            valid_d = 1'b0;
                        end
                    end else begin
                        cnt_d  = cnt_q + CntW'(1);
                        data_d = lfsr_next[LFSR_WIDTH-1];
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A new frame clears the capture even if the last payload bit just wrote it.
        if (frame_begin) begin
            fs_d   = 1'b1;
            seq_d  = '0;
            seqv_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= 1'b0;
            busy_q  <= 1'b0;
            fs_q    <= 1'b0;
            fd_q    <= 1'b0;
            seq_q   <= '0;
            seqv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            busy_q  <= (state_d != StIdle);
            fs_q    <= fs_d;
            fd_q    <= fd_d;
            seq_q   <= seq_d;
            seqv_q  <= seqv_d;
        end
    end

    assign out_valid       = valid_q;
    assign data_out        = tx_bit;
    assign busy            = busy_q;
    assign frame_start     = fs_q;
    assign frame_done      = fd_q;
    assign first_sequence  = seq_q;
    assign first_seq_valid = seqv_q;

endmodule

// File: tb/tb_frame_sig_gen.sv
// Directed bench for frame_sig_gen with default parameters and a reference PRBS15 model.
module tb_frame_sig_gen;

    localparam int PreLen   = 160;
    localparam int SyncLen  = 8;
    localparam int PayStart = PreLen + SyncLen;
    localparam int FrameLen = PreLen + SyncLen + 2048;
    localparam int CapAcc   = PayStart + 8;
    localparam int Budget   = 20000;

    logic       clk = 1'b0;
    logic       reset, start, continuous, reseed, out_ready, err_inject;
    logic       out_valid, data_out, busy, frame_start, frame_done, first_seq_valid;
    logic [7:0] first_sequence;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic bits     [FrameLen];
    logic ref_bits [FrameLen];
    int   accepted, gaps, unstable, seqv_early, seqv_late, fd_early;
    bit   inject_on = 1'b0;
    logic [14:0] model_lfsr;
    logic [7:0]  model_cap;

    always #5 clk = ~clk;

    frame_sig_gen dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .continuous      (continuous),
        .reseed          (reseed),
`ifdef SIGGEN_ERR_INJECT_EN
        .err_inject      (err_inject),
`endif
        .out_ready       (out_ready),
        .out_valid       (out_valid),
        .data_out        (data_out),
        .busy            (busy),
        .frame_start     (frame_start),
        .frame_done      (frame_done),
        .first_sequence  (first_sequence),
        .first_seq_valid (first_seq_valid)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference frame: zeros, sync 8'hFF, then PRBS15 (x^15+x^14+1) from the given state.
    task automatic build_ref(input logic [14:0] seed);
        logic [14:0] s;
        s = seed;
        for (int i = 0; i < FrameLen; i++) begin
            if (i < PreLen) begin
                ref_bits[i] = 1'b0;
            end else if (i < PayStart) begin
                ref_bits[i] = 1'b1;
            end else begin
                ref_bits[i] = s[14];
                s = {s[13:0], s[14] ^ s[13]};
            end
        end
        for (int k = 0; k < 8; k++) model_cap[7-k] = ref_bits[PayStart+k];
        model_lfsr = s;
    endtask

    function automatic int count_mismatch(input int upto);
        int m;
        m = 0;
        for (int i = 0; i < upto; i++) if (bits[i] !== ref_bits[i]) m++;
        return m;
    endfunction

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; continuous = 1'b0; reseed = 1'b0;
        out_ready = 1'b0; err_inject = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic check_reset(input string pfx);
        check_eq({pfx, "_valid"}, out_valid, 0);
        check_eq({pfx, "_data"}, data_out, 0);
        check_eq({pfx, "_busy"}, busy, 0);
        check_eq({pfx, "_fstart"}, frame_start, 0);
        check_eq({pfx, "_fdone"}, frame_done, 0);
        check_eq({pfx, "_seq"}, first_sequence, 0);
        check_eq({pfx, "_seqv"}, first_seq_valid, 0);
    endtask

    task automatic start_frame();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Accept up to 'limit' bits; inputs change 1 after the edge, outputs sampled 2 after.
    task automatic collect(input bit rnd, input int limit);
        int   cyc;
        logic stalled, held;
        cyc = 0; stalled = 1'b0; held = 1'b0;
        accepted = 0; gaps = 0; unstable = 0; seqv_early = 0; seqv_late = 0; fd_early = 0;
        while (accepted < limit && cyc < Budget) begin
            out_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            err_inject = inject_on && (accepted == PayStart);
            #1;
            if (!out_valid) gaps++;
            if (stalled && data_out !== held) unstable++;
            if (accepted < CapAcc && first_seq_valid) seqv_early++;
            if (accepted >= CapAcc && !first_seq_valid) seqv_late++;
            if (accepted > 0 && frame_done) fd_early++;
            if (out_valid && out_ready) begin
                bits[accepted] = data_out;
                accepted++;
                stalled = 1'b0;
            end else begin
                stalled = out_valid;
                held    = data_out;
            end
            @(posedge clk); #1;
            cyc++;
        end
        err_inject = 1'b0;
        check_eq("frame_accepts", accepted, limit);
    endtask

    initial begin
        do_reset();
        check_reset("rst");

        // Single shot, always ready
        build_ref(15'h5555);
        start_frame();
        check_eq("s1_valid", out_valid, 1);
        check_eq("s1_data", data_out, 0);
        check_eq("s1_fstart", frame_start, 1);
        check_eq("s1_busy", busy, 1);
        collect(1'b0, FrameLen);
        check_eq("s1_bits", count_mismatch(FrameLen), 0);
        check_eq("s1_last_pre", bits[PreLen-1], 0);
        check_eq("s1_first_sync", bits[PreLen], 1);
        check_eq("s1_last_sync", bits[PayStart-1], 1);
        check_eq("s1_capture", first_sequence, 8'hAA);
        check_eq("s1_seqv_early", seqv_early, 0);
        check_eq("s1_seqv_late", seqv_late, 0);
        check_eq("s1_gaps", gaps, 0);
        check_eq("s1_fd_early", fd_early, 0);
        check_eq("s1_fdone", frame_done, 1);
        check_eq("s1_end_valid", out_valid, 0);
        check_eq("s1_end_busy", busy, 0);
        @(posedge clk); #1;
        check_eq("s1_fdone_pulse", frame_done, 0);

        // Random backpressure
        do_reset();
        start_frame();
        collect(1'b1, FrameLen);
        check_eq("bp_bits", count_mismatch(FrameLen), 0);
        check_eq("bp_stable", unstable, 0);
        check_eq("bp_gaps", gaps, 0);
        check_eq("bp_capture", first_sequence, 8'hAA);

        // Continuous with reseed: two identical frames
        do_reset();
        continuous = 1'b1; reseed = 1'b1;
        start_frame();
        collect(1'b0, FrameLen);
        check_eq("cr1_bits", count_mismatch(FrameLen), 0);
        check_eq("cr_wrap_valid", out_valid, 1);
        check_eq("cr_wrap_fstart", frame_start, 1);
        check_eq("cr_wrap_data", data_out, 0);
        check_eq("cr_wrap_fdone", frame_done, 1);
        check_eq("cr_wrap_seq", first_sequence, 0);
        check_eq("cr_wrap_seqv", first_seq_valid, 0);
        continuous = 1'b0;
        collect(1'b1, FrameLen);
        check_eq("cr2_bits", count_mismatch(FrameLen), 0);
        check_eq("cr2_gaps", gaps, 0);
        check_eq("cr2_capture", first_sequence, 8'hAA);
        check_eq("cr2_end_valid", out_valid, 0);

        // Continuous without reseed: PRBS carries on
        do_reset();
        continuous = 1'b1; reseed = 1'b0;
        build_ref(15'h5555);
        start_frame();
        collect(1'b0, FrameLen);
        check_eq("cn1_bits", count_mismatch(FrameLen), 0);
        build_ref(model_lfsr);
        continuous = 1'b0;
        collect(1'b0, FrameLen);
        check_eq("cn2_bits", count_mismatch(FrameLen), 0);
        check_eq("cn2_capture", first_sequence, model_cap);
        check_eq("cn2_not_seed", first_sequence == 8'hAA, 0);

        // Reset mid-sync with the LFSR advanced from the previous test
        start_frame();
        collect(1'b0, PreLen + 5);
        check_eq("mr_busy", busy, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_reset("mr");
        build_ref(15'h5555);
        start_frame();
        collect(1'b0, FrameLen);
        check_eq("mr_bits", count_mismatch(FrameLen), 0);
        check_eq("mr_capture", first_sequence, 8'hAA);

`ifdef SIGGEN_ERR_INJECT_EN
        do_reset();
        build_ref(15'h5555);
        inject_on = 1'b1;
        start_frame();
        collect(1'b0, FrameLen);
        inject_on = 1'b0;
        check_eq("ei_capture", first_sequence, 8'h2A);
        check_eq("ei_bit0", bits[PayStart], ~ref_bits[PayStart]);
        check_eq("ei_bits", count_mismatch(FrameLen), 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/frame_sig_gen.md
# frame_sig_gen

Parametrised serial test-frame generator for the communication-system datapath. Each frame is a run of zero-valued preamble bits, then a configurable sync word, then a PRBS payload from an LFSR. Frames are emitted one bit per accepted transfer on a valid/ready stream, either single-shot or back-to-back. The first payload bits of each frame are captured for the display/compare logic downstream. The block sits at the head of the transmit chain and feeds the modulator/channel model.

## Interface
- PREAMBLE_LEN, 160: number of zero bits per frame, ≥1
- SYNC_LEN, 8: sync word length in bits, 1..32
- SYNC_WORD, 32'hFF: sync pattern; low SYNC_LEN bits are used, sent MSB first
- PAYLOAD_LEN, 2048: payload bits per frame, ≥CAPTURE_LEN
- CAPTURE_LEN, 8: number of captured leading payload bits, 1..32
- LFSR_WIDTH, 15: LFSR length, 2..32
- LFSR_TAPS, 15'h6000: feedback tap mask (x^15+x^14+1)
- LFSR_SEED, 15'h5555: reset/reseed value; an all-zero seed is replaced by 1
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a frame when IDLE; ignored otherwise
- continuous  in  1  when 1 at end of frame, start the next frame with no gap
- reseed  in  1  when 1 at frame start, reload the LFSR with LFSR_SEED
- out_ready  in  1  downstream accepts data_out
- out_valid  out  1  data_out holds a frame bit
- data_out  out  1  serial frame bit
- busy  out  1  state ≠ IDLE
- frame_start  out  1  one-cycle pulse on the first preamble bit
- frame_done  out  1  one-cycle pulse when the last payload bit is accepted
- first_sequence  out  CAPTURE_LEN  captured leading payload bits; first bit in the MSB
- first_seq_valid  out  1  first_sequence is complete for the current frame

## Operation
- States: IDLE → PREAMBLE → SYNC → PAYLOAD → (PREAMBLE | IDLE).
- Bit counter width is $clog2 of the largest of PREAMBLE_LEN, SYNC_LEN and PAYLOAD_LEN. It is cleared on each state change and advances only on accept (out_valid && out_ready).
- PREAMBLE: data_out=0 for PREAMBLE_LEN accepts.
- SYNC: data_out=SYNC_WORD[SYNC_LEN-1-cnt].
- PAYLOAD: data_out=lfsr[LFSR_WIDTH-1]. On each accept, lfsr ← {lfsr[W-2:0], ^(lfsr & LFSR_TAPS)}. The LFSR never advances outside accepted payload bits.
- Capture: the k-th accepted payload bit (k<CAPTURE_LEN) is written to first_sequence[CAPTURE_LEN-1-k]. first_seq_valid rises in the cycle after the CAPTURE_LEN-th accept.
- Frame start (from IDLE, or continuous wrap):
  - first_sequence ← 0
  - first_seq_valid ← 0
  - if reseed=1, lfsr ← LFSR_SEED
- Without reseed, the LFSR continues across frames.
- End of frame: on the last payload accept, pulse frame_done. If continuous=1, go to PREAMBLE, otherwise go to IDLE.
- start while busy is ignored. Holding continuous=0 mid-frame has no effect until the end of that frame.

## Timing
- Reset values:
  - state=IDLE
  - out_valid=0, data_out=0
  - busy=0, frame_start=0, frame_done=0
  - first_sequence=0, first_seq_valid=0
  - lfsr=LFSR_SEED, counter=0
- All outputs are registered.
- start sampled high in IDLE at edge N: out_valid=1, data_out=0, frame_start=1, busy=1 from edge N+1.
- Handshake:
  - data_out is stable while out_valid && !out_ready.
  - out_valid does not drop mid-frame.
  - A new bit appears the cycle after an accept.
- Continuous wrap: the last payload bit is followed by a preamble bit on the next accept, with no out_valid bubble. frame_start pulses with that bit.
- Single-shot end: out_valid=0 and busy=0 in the cycle after the last accept.
- Frame length in accepts: PREAMBLE_LEN+SYNC_LEN+PAYLOAD_LEN.
- reset mid-frame takes priority over all other inputs and restores the reset values on the next edge.

## Configuration
- SIGGEN_ERR_INJECT_EN defined:
  - Adds input err_inject (1 bit).
  - When err_inject=1 during an accepted payload bit, that bit is sent inverted.
  - The LFSR sequence is unaffected.
  - The captured bit is the inverted (transmitted) value.
- SIGGEN_ERR_INJECT_EN undefined: no err_inject port and no inversion logic.

## Structure
- Package siggen_pkg holds:
  - state enum (IDLE, PREAMBLE, SYNC, PAYLOAD)
  - default PRBS15 taps/seed constants
  - a $clog2-based counter-width function
- One sub-module, siggen_lfsr: a parametrised shift/advance/load LFSR with an enable, a load port and a zero-seed guard.
- FSM, counter and capture logic live in frame_sig_gen.

## Test plan
- Defaults, out_ready=1, start pulse:
  - 160 zeros, then 8 ones, then payload
  - first_sequence=8'hAA (SEED[14:7]), first_seq_valid after accept 176
  - frame_done at accept 2216
- out_ready toggled pseudo-randomly: the bitstream is identical to the out_ready=1 run, and data_out is stable during stalls.
- continuous=1 with reseed=1: frame 2 is bit-identical to frame 1, with no out_valid gap and a frame_start pulse on the wrap bit.
- continuous=1 with reseed=0: the frame-2 payload continues the PRBS15 sequence, and first_sequence differs from 8'hAA.
- reset asserted mid-SYNC, then start: the output restarts with a full 160-bit preamble and the LFSR is back at 15'h5555.
- SIGGEN_ERR_INJECT_EN with err_inject on payload bit 0: first_sequence=8'h2A, and later bits match the reference PRBS.
